// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream bundle used by the packet generator (Master) and its consumers (Slave).
interface AXIS_int #(
  parameter int DATA_BYTES = 8,
  parameter int ID_W       = 1,
  parameter int DEST_W     = 1,
  parameter int USER_W     = 1
);
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [DATA_BYTES-1:0]   tstrb;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;
  logic [ID_W-1:0]         tid;
  logic [DEST_W-1:0]       tdest;
  logic [USER_W-1:0]       tuser;

  modport Master (output tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser, input tready);
  modport Slave  (input tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream burst packet source that also publishes the expected-packet tables for a checker.
// Optional build macro AXIS_PKT_GEN_TVALID_THROTTLE_EN adds LFSR-driven tvalid throttling.
module axis_pkt_gen #(
  parameter int DATA_BYTES      = 8,
  parameter int MTU_BYTES       = 256,
  parameter int NUM_PKT_IDS     = 4,
  parameter int NUM_PKT_IDS_LOG = (NUM_PKT_IDS > 1) ? $clog2(NUM_PKT_IDS) : 1,
  parameter int NUM_PACKETS     = 8,
  parameter int LEN_W           = $clog2(MTU_BYTES),
  parameter int CNT_W           = $clog2(NUM_PACKETS + 1)
) (
  input  logic                                       clk,
  input  logic                                       aresetn,
  input  logic                                       start,
  input  logic [CNT_W-1:0]                           cfg_num_pkts,
  input  logic [LEN_W-1:0]                           cfg_min_len,
  input  logic [LEN_W-1:0]                           cfg_max_len,
  input  logic [LEN_W-1:0]                           cfg_len_step,
  input  logic [NUM_PKT_IDS_LOG-1:0]                 cfg_id_base,
  AXIS_int.Master                                    axis_packet_out,
  output logic [NUM_PKT_IDS_LOG-1:0]                 packet_out_id,
  output logic                                       busy,
  output logic                                       done,
  output logic [CNT_W-1:0]                           num_tx_pkts,
  output logic [NUM_PACKETS-1:0][MTU_BYTES*8-1:0]    expected_pkts,
  output logic [NUM_PACKETS-1:0][LEN_W-1:0]          expected_blens,
  output logic [NUM_PACKETS-1:0][NUM_PKT_IDS_LOG-1:0] expected_ids
);

  localparam int PKT_W  = MTU_BYTES * 8;
  localparam int DATA_W = DATA_BYTES * 8;
  localparam int IDX_W  = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  function automatic logic [7:0] pay_byte(input logic [CNT_W-1:0] idx, input int k);
    return 8'(int'(idx) * 17 + k);
  endfunction

  function automatic logic [PKT_W-1:0] build_pkt(input logic [CNT_W-1:0] idx,
                                                 input logic [LEN_W-1:0] len);
    logic [PKT_W-1:0] r;
    r = '0;
    for (int k = 0; k < MTU_BYTES; k++) begin
      if (k < int'(len)) r[8*k +: 8] = pay_byte(idx, k);
    end
    return r;
  endfunction

  function automatic logic [DATA_BYTES-1:0] beat_keep(input logic [LEN_W-1:0] len,
                                                      input logic [LEN_W-1:0] beat);
    logic [DATA_BYTES-1:0] r;
    for (int j = 0; j < DATA_BYTES; j++) r[j] = (int'(beat) * DATA_BYTES + j) < int'(len);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [CNT_W-1:0] idx,
                                                  input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] beat);
    logic [DATA_W-1:0] r;
    int                k;
    r = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      k = int'(beat) * DATA_BYTES + j;
      if (k < int'(len)) r[8*j +: 8] = pay_byte(idx, k);
    end
    return r;
  endfunction

  state_t                                     state_q;
  logic [CNT_W-1:0]                           num_q, idx_q, num_tx_q;
  logic [LEN_W-1:0]                           min_q, max_q, step_q, len_q, beat_q;
  logic [NUM_PKT_IDS_LOG-1:0]                 id_q;
  logic                                       busy_q, done_q, tvalid_q, tlast_q;
  logic [DATA_W-1:0]                          tdata_q;
  logic [DATA_BYTES-1:0]                      tkeep_q;
  logic [NUM_PACKETS-1:0][PKT_W-1:0]          exp_pkts_q;
  logic [NUM_PACKETS-1:0][LEN_W-1:0]          exp_blens_q;
  logic [NUM_PACKETS-1:0][NUM_PKT_IDS_LOG-1:0] exp_ids_q;

  logic [CNT_W-1:0]           num_d;
  logic [LEN_W-1:0]           min_d, max_d, next_len_d, beat_sel_d;
  logic [LEN_W:0]             len_sum_d;
  logic [NUM_PKT_IDS_LOG-1:0] id_base_d, next_id_d;
  logic [DATA_W-1:0]          beat_data_d;
  logic [DATA_BYTES-1:0]      beat_keep_d;
  logic                       beat_last_d;
  logic [PKT_W-1:0]           pkt_d;
  logic [IDX_W-1:0]           idx_sel;
  logic                       allow;

`ifdef AXIS_PKT_GEN_TVALID_THROTTLE_EN
  logic [15:0] lfsr_q;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= 16'hACE1;
    else          lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign allow = |lfsr_q[1:0];
`else
  assign allow = 1'b1;
`endif

  always_comb begin
    num_d      = (cfg_num_pkts > CNT_W'(NUM_PACKETS)) ? CNT_W'(NUM_PACKETS) : cfg_num_pkts;
    min_d      = (cfg_min_len == '0) ? LEN_W'(1) : cfg_min_len;
    max_d      = (cfg_max_len < min_d) ? min_d : cfg_max_len;
    id_base_d  = (int'(cfg_id_base) >= NUM_PKT_IDS) ? '0 : cfg_id_base;
    next_id_d  = (int'(id_q) == NUM_PKT_IDS - 1) ? '0 : id_q + NUM_PKT_IDS_LOG'(1);
    // The extra carry bit catches LEN_W overflow, which also wraps to min.
    len_sum_d  = {1'b0, len_q} + {1'b0, step_q};
    next_len_d = (len_sum_d[LEN_W] || (len_sum_d[LEN_W-1:0] > max_q)) ? min_q
                                                                       : len_sum_d[LEN_W-1:0];
    // LOAD prepares beat 0; SEND prepares the beat after the current one.
    beat_sel_d  = (state_q == S_SEND) ? beat_q + LEN_W'(1) : '0;
    beat_data_d = beat_data(idx_q, len_q, beat_sel_d);
    beat_keep_d = beat_keep(len_q, beat_sel_d);
    beat_last_d = ((int'(beat_sel_d) + 1) * DATA_BYTES) >= int'(len_q);
    pkt_d       = build_pkt(idx_q, len_q);
    idx_sel     = idx_q[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      idx_q       <= '0;
      num_tx_q    <= '0;
      min_q       <= '0;
      max_q       <= '0;
      step_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      id_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      exp_pkts_q  <= '0;
      exp_blens_q <= '0;
      exp_ids_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_tx_q <= '0;
            num_q    <= num_d;
            min_q    <= min_d;
            max_q    <= max_d;
            step_q   <= cfg_len_step;
            idx_q    <= '0;
            len_q    <= min_d;
            id_q     <= id_base_d;
            if (num_d == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          exp_pkts_q[idx_sel]  <= pkt_d;
          exp_blens_q[idx_sel] <= len_q;
          exp_ids_q[idx_sel]   <= id_q;
          beat_q   <= '0;
          tdata_q  <= beat_data_d;
          tkeep_q  <= beat_keep_d;
          tlast_q  <= beat_last_d;
          tvalid_q <= allow;
          state_q  <= S_SEND;
        end
        S_SEND: begin
          if (tvalid_q && axis_packet_out.tready) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              num_tx_q <= num_tx_q + CNT_W'(1);
              if (idx_q + CNT_W'(1) == num_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                idx_q   <= idx_q + CNT_W'(1);
                len_q   <= next_len_d;
                id_q    <= next_id_d;
                state_q <= S_LOAD;
              end
            end else begin
              beat_q   <= beat_sel_d;
              tdata_q  <= beat_data_d;
              tkeep_q  <= beat_keep_d;
              tlast_q  <= beat_last_d;
              tvalid_q <= allow;
            end
          end else if (!tvalid_q) begin
            tvalid_q <= allow;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axis_packet_out.tdata  = tdata_q;
  assign axis_packet_out.tkeep  = tkeep_q;
  assign axis_packet_out.tstrb  = tkeep_q;
  assign axis_packet_out.tlast  = tlast_q;
  assign axis_packet_out.tvalid = tvalid_q;
  assign axis_packet_out.tid    = id_q;
  assign axis_packet_out.tdest  = '0;
  assign axis_packet_out.tuser  = '0;

  assign packet_out_id  = id_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign num_tx_pkts    = num_tx_q;
  assign expected_pkts  = exp_pkts_q;
  assign expected_blens = exp_blens_q;
  assign expected_ids   = exp_ids_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed, table-driven bench for axis_pkt_gen (DATA_BYTES=8, MTU=256, 4 IDs, 8 table entries).
module tb_axis_pkt_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  aresetn, start;
  logic [3:0]            cfg_num_pkts;
  logic [7:0]            cfg_min_len, cfg_max_len, cfg_len_step;
  logic [1:0]            cfg_id_base;
  logic [1:0]            packet_out_id;
  logic                  busy, done;
  logic [3:0]            num_tx_pkts;
  logic [7:0][2047:0]    expected_pkts;
  logic [7:0][7:0]       expected_blens;
  logic [7:0][1:0]       expected_ids;

  AXIS_int #(.DATA_BYTES(8), .ID_W(2), .DEST_W(1), .USER_W(1)) axis_if ();

  axis_pkt_gen #(
    .DATA_BYTES(8), .MTU_BYTES(256), .NUM_PKT_IDS(4), .NUM_PACKETS(8)
  ) dut (
    .clk(clk), .aresetn(aresetn), .start(start),
    .cfg_num_pkts(cfg_num_pkts), .cfg_min_len(cfg_min_len), .cfg_max_len(cfg_max_len),
    .cfg_len_step(cfg_len_step), .cfg_id_base(cfg_id_base),
    .axis_packet_out(axis_if),
    .packet_out_id(packet_out_id), .busy(busy), .done(done), .num_tx_pkts(num_tx_pkts),
    .expected_pkts(expected_pkts), .expected_blens(expected_blens), .expected_ids(expected_ids)
  );

  typedef struct {
    logic [3:0]      num;
    logic [7:0]      mn, mx, st;
    logic [1:0]      idb;
    bit              tog;
    bit              poke;
    int              cnt;
    logic [7:0][7:0] lens;
    logic [7:0][1:0] ids;
  } vec_t;

  vec_t            vt [7];
  logic [7:0][7:0] sh_len;
  logic [7:0][1:0] sh_id;
  int              total = 0;
  int              bad = 0;

  function automatic logic [7:0][7:0] lens8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [7:0][1:0] ids8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {2'(a7), 2'(a6), 2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_pkt(input int n, input int len);
    int         fk;
    logic [7:0] e;
    fk = -1;
    for (int k = 0; k < 256; k++) begin
      e = (k < len) ? 8'(n * 17 + k) : 8'h00;
      if (fk < 0 && expected_pkts[n][8*k +: 8] !== e) fk = k;
    end
    if (fk < 0) fk = len - 1;
    e = (fk < len) ? 8'(n * 17 + fk) : 8'h00;
    chk($sformatf("pkt%0d byte%0d", n, fk), 128'(expected_pkts[n][8*fk +: 8]), 128'(e));
  endtask

  task automatic run_burst(input int v);
    int              p, b, cyc, dones, post, len;
    bit              hold_pending, rdy, saw_valid, saw_busy;
    logic [63:0]     hd, exp_d;
    logic [7:0]      hk, exp_k;
    logic            hl, exp_l;
    bit              pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    cfg_num_pkts = vt[v].num;
    cfg_min_len  = vt[v].mn;
    cfg_max_len  = vt[v].mx;
    cfg_len_step = vt[v].st;
    cfg_id_base  = vt[v].idb;
    axis_if.tready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (vt[v].cnt > 0) chk($sformatf("v%0d busy after start", v), 128'(busy), 128'(1));
    p = 0; b = 0; cyc = 0; dones = 0; post = 0;
    hold_pending = 0; saw_valid = 0; saw_busy = 0;
    hd = '0; hk = '0; hl = 1'b0;
    while (post < 3 && cyc < 2000) begin
      if (done) dones++;
      if (dones > 0) post++;
      if (axis_if.tvalid) saw_valid = 1;
      if (busy) saw_busy = 1;
      if (hold_pending) begin
        chk($sformatf("v%0d hold c%0d", v, cyc),
            128'({axis_if.tvalid, axis_if.tdata, axis_if.tkeep, axis_if.tlast}),
            128'({1'b1, hd, hk, hl}));
        hold_pending = 0;
      end
      start = vt[v].poke && (cyc == 4);
      if (start) begin
        cfg_num_pkts = 4'd1;
        cfg_min_len  = 8'd2;
      end
      rdy = vt[v].tog ? pat[cyc % 4] : 1'b1;
      axis_if.tready = rdy;
      if (axis_if.tvalid) begin
        if (rdy) begin
          if (p >= vt[v].cnt) begin
            total++; bad++;
            $display("FAIL v%0d extra beat: got packet %0d want at most %0d", v, p, vt[v].cnt);
          end else begin
            len = int'(vt[v].lens[p]);
            exp_d = '0; exp_k = '0;
            for (int j = 0; j < 8; j++) begin
              if (b * 8 + j < len) begin
                exp_d[8*j +: 8] = 8'(p * 17 + b * 8 + j);
                exp_k[j] = 1'b1;
              end
            end
            exp_l = ((b + 1) * 8 >= len);
            chk($sformatf("v%0d p%0d b%0d beat", v, p, b),
                128'({axis_if.tdata, axis_if.tkeep, axis_if.tstrb, axis_if.tlast, axis_if.tid}),
                128'({exp_d, exp_k, exp_k, exp_l, vt[v].ids[p]}));
            if (axis_if.tlast) begin p++; b = 0; end
            else b++;
          end
        end else begin
          hold_pending = 1;
          hd = axis_if.tdata; hk = axis_if.tkeep; hl = axis_if.tlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    axis_if.tready = 1'b1;
    chk($sformatf("v%0d done pulses", v), 128'(dones), 128'(1));
    chk($sformatf("v%0d packets seen", v), 128'(p), 128'(vt[v].cnt));
    chk($sformatf("v%0d num_tx_pkts", v), 128'(num_tx_pkts), 128'(vt[v].cnt));
    chk($sformatf("v%0d busy at end", v), 128'(busy), 128'(0));
    chk($sformatf("v%0d tdest/tuser", v), 128'({axis_if.tdest, axis_if.tuser}), 128'(0));
    if (vt[v].cnt == 0)
      chk($sformatf("v%0d idle activity", v), 128'({saw_valid, saw_busy}), 128'(0));
    for (int i = 0; i < vt[v].cnt; i++) begin
      sh_len[i] = vt[v].lens[i];
      sh_id[i]  = vt[v].ids[i];
    end
    chk($sformatf("v%0d blens", v), 128'(expected_blens), 128'(sh_len));
    chk($sformatf("v%0d ids", v), 128'(expected_ids), 128'(sh_id));
    for (int i = 0; i < vt[v].cnt; i++) chk_pkt(i, int'(vt[v].lens[i]));
  endtask

  initial begin
    int n;
    vt[0] = '{num:4'd3, mn:8'd5, mx:8'd20, st:8'd7, idb:2'd2, tog:1'b0, poke:1'b0, cnt:3,
              lens:lens8(5, 12, 19, 0, 0, 0, 0, 0), ids:ids8(2, 3, 0, 0, 0, 0, 0, 0)};
    vt[1] = '{num:4'd3, mn:8'd16, mx:8'd20, st:8'd8, idb:2'd0, tog:1'b0, poke:1'b1, cnt:3,
              lens:lens8(16, 16, 16, 0, 0, 0, 0, 0), ids:ids8(0, 1, 2, 0, 0, 0, 0, 0)};
    vt[2] = '{num:4'd3, mn:8'd5, mx:8'd20, st:8'd7, idb:2'd2, tog:1'b1, poke:1'b0, cnt:3,
              lens:lens8(5, 12, 19, 0, 0, 0, 0, 0), ids:ids8(2, 3, 0, 0, 0, 0, 0, 0)};
    vt[3] = '{num:4'd0, mn:8'd5, mx:8'd20, st:8'd7, idb:2'd1, tog:1'b0, poke:1'b0, cnt:0,
              lens:lens8(0, 0, 0, 0, 0, 0, 0, 0), ids:ids8(0, 0, 0, 0, 0, 0, 0, 0)};
    vt[4] = '{num:4'd12, mn:8'd1, mx:8'd8, st:8'd3, idb:2'd3, tog:1'b0, poke:1'b0, cnt:8,
              lens:lens8(1, 4, 7, 1, 4, 7, 1, 4), ids:ids8(3, 0, 1, 2, 3, 0, 1, 2)};
    vt[5] = '{num:4'd2, mn:8'd0, mx:8'd0, st:8'd0, idb:2'd1, tog:1'b0, poke:1'b0, cnt:2,
              lens:lens8(1, 1, 0, 0, 0, 0, 0, 0), ids:ids8(1, 2, 0, 0, 0, 0, 0, 0)};
    vt[6] = '{num:4'd3, mn:8'd200, mx:8'd255, st:8'd50, idb:2'd0, tog:1'b1, poke:1'b0, cnt:3,
              lens:lens8(200, 250, 200, 0, 0, 0, 0, 0), ids:ids8(0, 1, 2, 0, 0, 0, 0, 0)};
    sh_len = '0;
    sh_id  = '0;
    aresetn = 1'b0;
    start = 1'b0;
    cfg_num_pkts = '0; cfg_min_len = '0; cfg_max_len = '0; cfg_len_step = '0; cfg_id_base = '0;
    axis_if.tready = 1'b1;
    #23;
    chk("reset ctrl", 128'({busy, done, axis_if.tvalid, axis_if.tlast, num_tx_pkts, packet_out_id}),
        128'(0));
    chk("reset blens", 128'(expected_blens), 128'(0));
    chk("reset ids", 128'(expected_ids), 128'(0));
    chk("reset pkt0 low", expected_pkts[0][127:0], 128'(0));
    @(negedge clk);
    aresetn = 1'b1;

    for (int v = 0; v < 7; v++) run_burst(v);

    // Abort mid packet 1 with an asynchronous reset, then run a clean burst.
    @(negedge clk);
    cfg_num_pkts = 4'd3; cfg_min_len = 8'd5; cfg_max_len = 8'd20;
    cfg_len_step = 8'd7; cfg_id_base = 2'd2;
    axis_if.tready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(axis_if.tvalid && packet_out_id == 2'd3)) begin
      @(negedge clk);
      n++;
    end
    chk("rst reach pkt1", 128'(n < 100), 128'(1));
    chk("rst pre count", 128'(num_tx_pkts), 128'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst abort ctrl", 128'({axis_if.tvalid, busy, done, num_tx_pkts, packet_out_id}),
        128'(0));
    chk("rst abort blens", 128'(expected_blens), 128'(0));
    @(negedge clk);
    chk("rst no done", 128'(done), 128'(0));
    aresetn = 1'b1;
    sh_len = '0;
    sh_id  = '0;
    run_burst(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- Synthesizable AXI-Stream packet source that sits directly upstream of the per-port packet checker.
- Emits a programmed burst of packets with deterministic payloads, incrementing lengths and wrapping packet IDs.
- In parallel it publishes the expected-packet tables (payload, byte length, ID) and a transmitted-packet count, so the checker downstream can compare received traffic without any testbench-side modelling.

Parameters:
- DATA_BYTES, 8: AXIS beat width in bytes; must be >0.
- MTU_BYTES, 256: maximum packet length; must be ≥ DATA_BYTES.
- NUM_PKT_IDS, 4: number of distinct packet IDs; must be ≥ 1.
- NUM_PKT_IDS_LOG, max(1,$clog2(NUM_PKT_IDS)): ID width.
- NUM_PACKETS, 8: depth of the expected tables; maximum packets per burst.
- LEN_W, $clog2(MTU_BYTES): byte-length width; legal lengths are 1..min(MTU_BYTES, 2**LEN_W-1).
- CNT_W, $clog2(NUM_PACKETS+1): width of packet counters.

Ports:
- clk  in  1  clock for all logic and for axis_packet_out.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts a burst when in IDLE, ignored otherwise.
- cfg_num_pkts  in  CNT_W  packets in the burst; 0 gives an immediate done; values above NUM_PACKETS are clamped to NUM_PACKETS.
- cfg_min_len  in  LEN_W  length of the first packet; 0 is treated as 1.
- cfg_max_len  in  LEN_W  length ceiling; values below cfg_min_len are treated as equal to cfg_min_len.
- cfg_len_step  in  LEN_W  length increment per packet.
- cfg_id_base  in  NUM_PKT_IDS_LOG  ID of the first packet; values ≥ NUM_PKT_IDS are treated as 0.
- axis_packet_out  AXIS_int.Master  DATA_BYTES  generated packet stream.
- packet_out_id  out  NUM_PKT_IDS_LOG  ID of the packet currently on the bus.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the last packet's tlast handshake completes.
- num_tx_pkts  out  CNT_W  packets fully sent (tlast handshaked) in this burst.
- expected_pkts  out  [NUM_PACKETS-1:0][MTU_BYTES*8-1:0]  payload of entry n; byte k occupies bits [8k+7:8k].
- expected_blens  out  [NUM_PACKETS-1:0][LEN_W-1:0]  byte length of entry n.
- expected_ids  out  [NUM_PACKETS-1:0][NUM_PKT_IDS_LOG-1:0]  ID of entry n.

Behaviour:
- Reset: state = IDLE. busy, done, tvalid, tlast and num_tx_pkts = 0. All expected tables = 0. packet_out_id = 0.
- All cfg_* inputs are sampled on the start cycle and held for the whole burst.
- States:
  - IDLE: on start, if the clamped packet count is 0, pulse done and stay in IDLE; otherwise go to LOAD. Clear num_tx_pkts on start.
  - LOAD (1 cycle): write entry idx (payload, length, ID); drive packet_out_id; go to SEND. Each entry is therefore valid before the first beat of its packet.
  - SEND: drive beats. Advance only when tvalid && tready.
    - On the tlast handshake: increment num_tx_pkts.
    - If idx+1 equals the clamped count: pulse done and go to IDLE.
    - Otherwise: increment idx and go to LOAD.
- Payload: byte k of packet idx = (idx*17 + k) mod 256. Bytes at k ≥ len are 0 in expected_pkts.
- Beats per packet = ceil(len/DATA_BYTES). Each beat carries bytes b*DATA_BYTES.. in little-endian lane order.
- Final beat: tkeep = low (len - (beats-1)*DATA_BYTES) bits set; unused lanes are 0. tkeep is all ones on every other beat. tstrb = tkeep.
- tid = packet_out_id. tdest = 0. tuser = 0.
- Length sequence:
  - First packet: len = min.
  - Next: len + step. If that exceeds max, or the LEN_W-bit addition overflows, wrap to min.
  - step 0 gives constant length.
- ID sequence: starts at cfg_id_base; increments per packet; wraps from NUM_PKT_IDS-1 to 0.
- AXIS rules:
  - tvalid never drops while tready is low.
  - tdata, tkeep and tlast are stable until the handshake.
  - Back-to-back packets have exactly one idle LOAD cycle between them.
- start while busy is ignored.
- Reset mid-burst aborts immediately: tvalid = 0 asynchronously and all state is cleared. No partial done is issued.
- Entries at idx ≥ burst count keep their previous contents.

Optional Feature:
- Macro: AXIS_PKT_GEN_TVALID_THROTTLE_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset-loaded) steps every cycle.
  - In SEND, a new beat is presented only when LFSR[1:0] != 0.
  - Once tvalid is asserted it stays high until the handshake, preserving AXIS rules.
- Undefined: tvalid is high every SEND cycle.
- Payload, lengths, IDs and expected tables are identical in both builds.

Test Plan:
- DATA_BYTES=8, cfg_num_pkts=3, min=5, max=20, step=7, id_base=2, NUM_PKT_IDS=4, tready=1:
  - lengths 5, 12, 19; IDs 2, 3, 0.
  - Packet 1 has 2 beats; last tkeep=8'h0F.
  - done pulses once; num_tx_pkts=3.
- min=16, max=20, step=8, 3 packets: lengths 16, 16, 16 (24 > 20 wraps to min). Last beat tkeep=8'hFF; expected_blens all 16.
- tready toggles 1-0-0-1 throughout a 3-packet burst: tdata and tkeep are held while tready=0, and the received payload byte k of packet 1 equals 17+k.
- cfg_num_pkts=0: done pulses the cycle after start; no tvalid; busy stays 0.
- cfg_num_pkts=12 with NUM_PACKETS=8: exactly 8 packets are sent; num_tx_pkts=8.
- aresetn asserted mid packet 1 then released, then a new start: tvalid drops at once, num_tx_pkts=0, and the new burst starts at idx 0 with the correct length and ID.
